// File: rtl/sram_wb_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge.
// Holds the FSM state encodings, the SRAM data width and the byte-lane width helper.
package sram_wb_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ACT   = 3'd1,
        S_WR_ADR   = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_TURN     = 3'd5,
        S_ACK      = 3'd6
    } state_e;

    // log2 of the Wishbone bytes per word (legal widths are 1, 2 and 4)
    function automatic int lb_of(input int bytes);
        return (bytes >= 4) ? 2 : ((bytes == 2) ? 1 : 0);
    endfunction

endpackage

// File: rtl/sram_dq_iob.sv
// Bidirectional IO buffers for the 8-bit SRAM data bus.
// The only technology-specific part of the controller; swap the per-bit buffer for a vendor primitive here.
module sram_dq_iob (
    inout  wire  [7:0] pad,
    input  logic       oe,
    input  logic [7:0] d_out,
    output logic [7:0] d_in
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign pad[gi]  = oe ? d_out[gi] : 1'bz;
            assign d_in[gi] = pad[gi];
        end
    endgenerate

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave bridging 8*BYTES-bit words onto an 8-bit asynchronous SRAM.
// Each selected byte lane becomes one SRAM access with programmable read, write and turnaround timing.
module sram_wb_ctrl
    import sram_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int BYTES   = 4,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    output logic                              oe_o,
    output logic                              ce_o,
    output logic                              we_o,
    output logic [ADDR_W-1:0]                 ad_o,
    inout  wire  [DATA_W-1:0]                 dq_io,
    input  logic                              wb_cyc_i,
    input  logic                              wb_stb_i,
    input  logic                              wb_we_i,
    input  logic [ADDR_W-lb_of(BYTES)-1:0]    wb_adr_i,
    input  logic [BYTES-1:0]                  wb_sel_i,
    input  logic [DATA_W*BYTES-1:0]           wb_dat_i,
    output logic [DATA_W*BYTES-1:0]           wb_dat_o,
    output logic                              wb_ack_o,
    output logic                              busy_o
);

    localparam int LB    = lb_of(BYTES);
    localparam int LW    = (LB > 0) ? LB : 1;
    localparam int AW    = ADDR_W - LB;
    localparam int DW    = DATA_W * BYTES;
    localparam int MAXRW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int MAXW  = (MAXRW > TURN) ? MAXRW : TURN;
    localparam int CW    = $clog2(MAXW + 1);
    localparam bit HAS_TURN = (TURN > 0);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [BYTES-1:0]  sel_q, sel_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic              we_txn_q, we_txn_d;
    logic              abort_q, abort_d;
    logic              oe_q, oe_d, ce_q, ce_d, we_q, we_d;
    logic              ack_q, ack_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [DATA_W-1:0] dq_in;

    logic              fin, go, go_we;
    logic [LW-1:0]     go_idx;
    logic [AW-1:0]     go_adr;
    logic [DW-1:0]     go_dat;
    logic [LW:0]       first_r, nxt_r;

    // Returns {found, index} of the lowest set bit of sel at or above start.
    function automatic logic [LW:0] find_lane(input logic [BYTES-1:0] sel, input int start);
        logic [LW:0] r;
        r = '0;
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (i >= start && sel[i]) r = {1'b1, LW'(i)};
        end
        return r;
    endfunction

    assign first_r = find_lane(wb_sel_i, 0);
    assign nxt_r   = find_lane(sel_q, int'(lane_q) + 1);

    sram_dq_iob u_iob (
        .pad   (dq_io),
        .oe    (dq_oe_q),
        .d_out (dq_out_q),
        .d_in  (dq_in)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        dat_d    = dat_q;
        we_txn_d = we_txn_q;
        oe_d     = oe_q;
        ce_d     = ce_q;
        we_d     = we_q;
        ack_d    = 1'b0;
        dq_oe_d  = dq_oe_q;
        dq_out_d = dq_out_q;
        ad_d     = ad_q;
        fin      = 1'b0;
        go       = 1'b0;
        go_idx   = lane_q;
        go_we    = (state_q == S_IDLE) ? wb_we_i  : we_txn_q;
        go_adr   = (state_q == S_IDLE) ? wb_adr_i : adr_q;
        go_dat   = (state_q == S_IDLE) ? wb_dat_i : wdat_q;
        // A dropped cyc is remembered so the access in flight can still finish cleanly.
        abort_d  = (state_q != S_IDLE) && (abort_q || !wb_cyc_i);

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d    = wb_adr_i;
                    sel_d    = wb_sel_i;
                    wdat_d   = wb_dat_i;
                    we_txn_d = wb_we_i;
                    dat_d    = '0;
                    if (first_r[LW]) begin
                        go     = 1'b1;
                        go_idx = first_r[LW-1:0];
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
                end
            end
            S_RD_ACT: begin
                if (cnt_q == CW'(1)) begin
                    dat_d = dat_q | (DW'(dq_in) << (DATA_W * int'(lane_q)));
                    ce_d  = 1'b1;
                    oe_d  = 1'b1;
                    fin   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR_ADR: begin
                state_d = S_WR_PULSE;
                we_d    = 1'b0;
                cnt_d   = CW'(WR_WAIT);
            end
            S_WR_PULSE: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_WR_HOLD;
                    we_d    = 1'b1;
                    ce_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR_HOLD: begin
                dq_oe_d = 1'b0;
                fin     = 1'b1;
            end
            S_TURN: begin
                if (abort_d) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    go     = 1'b1;
                    go_idx = lane_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            if (abort_d) begin
                state_d = S_IDLE;
            end else if (nxt_r[LW]) begin
                lane_d = nxt_r[LW-1:0];
                if (HAS_TURN) begin
                    state_d = S_TURN;
                    cnt_d   = CW'(TURN);
                end else begin
                    go     = 1'b1;
                    go_idx = nxt_r[LW-1:0];
                end
            end else begin
                state_d = S_ACK;
                ack_d   = 1'b1;
            end
        end

        // Start the strobe sequence for lane go_idx; address and strobes change on the same edge.
        if (go) begin
            lane_d = go_idx;
            ad_d   = (ADDR_W'(go_adr) << LB) | ADDR_W'(go_idx);
            ce_d   = 1'b0;
            if (go_we) begin
                state_d  = S_WR_ADR;
                we_d     = 1'b1;
                oe_d     = 1'b1;
                dq_oe_d  = 1'b1;
                dq_out_d = DATA_W'(go_dat >> (DATA_W * int'(go_idx)));
            end else begin
                state_d = S_RD_ACT;
                oe_d    = 1'b0;
                cnt_d   = CW'(RD_WAIT);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lane_q   <= '0;
            adr_q    <= '0;
            sel_q    <= '0;
            wdat_q   <= '0;
            dat_q    <= '0;
            we_txn_q <= 1'b0;
            abort_q  <= 1'b0;
            oe_q     <= 1'b1;
            ce_q     <= 1'b1;
            we_q     <= 1'b1;
            ack_q    <= 1'b0;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
            ad_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            dat_q    <= dat_d;
            we_txn_q <= we_txn_d;
            abort_q  <= abort_d;
            oe_q     <= oe_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
            ad_q     <= ad_d;
        end
    end

    assign oe_o     = oe_q;
    assign ce_o     = ce_q;
    assign we_o     = we_q;
    assign ad_o     = ad_q;
    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule
